// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared types and constants for the regfile writeback block
// Contents: default address/data widths, the buffered-entry struct and the R0 constant.
package regfile_wb_pkg;

    localparam int WB_AW = 5;
    localparam int WB_DW = 32;

    // Writes to R0 are consumed but never reach the regfile.
    localparam logic [WB_AW-1:0] WB_R0 = '0;

    typedef struct packed {
        logic [WB_AW-1:0] rd;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// rtl/regfile_wb_fifo.sv - circular buffer for multdiv results that lost arbitration
// Ports:
//   clock, ctrl_reset       clock and synchronous active-high reset
//   push_i, push_entry_i    enqueue one entry (caller guarantees not full)
//   pop_i, head_o           dequeue the oldest entry (caller guarantees not empty)
//   count_o, full_o, empty_o occupancy
//   qa_rd_i/qb_rd_i/qc_rd_i  query addresses; match_*_o flag valid entries whose rd equals them
module regfile_wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             push_i,
    input  wb_entry_t        push_entry_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o,
    input  logic [WB_AW-1:0] qa_rd_i,
    input  logic [WB_AW-1:0] qb_rd_i,
    input  logic [WB_AW-1:0] qc_rd_i,
    output logic [DEPTH-1:0] match_a_o,
    output logic [DEPTH-1:0] match_b_o,
    output logic [DEPTH-1:0] match_c_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        int off;
        off   = 0;
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = i - int'(rd_ptr_q);
            if (off < 0) off = off + DEPTH;
            valid[i] = (off < int'(count_q));
        end
    end

    always_comb begin
        match_a_o = '0;
        match_b_o = '0;
        match_c_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_a_o[i] = valid[i] && (mem_q[i].rd == qa_rd_i) && (qa_rd_i != WB_R0);
            match_b_o[i] = valid[i] && (mem_q[i].rd == qb_rd_i) && (qb_rd_i != WB_R0);
            match_c_o[i] = valid[i] && (mem_q[i].rd == qc_rd_i) && (qc_rd_i != WB_R0);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    a_no_overflow:  assert property (@(posedge clock) disable iff (ctrl_reset) !(push_i && full_o));
    a_no_underflow: assert property (@(posedge clock) disable iff (ctrl_reset) !(pop_i && empty_o));

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - merges pipeline and multdiv results onto the regfile write port
// Optional feature macro: REGFILE_WB_FWD_EN (address-compare forwarding and precise stalls).
// Ports:
//   clock, ctrl_reset                      clock and synchronous active-high reset
//   pipe_valid/pipe_rd/pipe_data           in-order result, always consumed
//   md_valid/md_ready/md_rd/md_data        multdiv result handshake
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg  registered regfile write port
//   fwd_regA/B, fwd_hitA/B, fwd_dataA/B    read-after-write forwarding for the two read ports
//   fwd_stallA/B                           read address waits on a buffered multdiv result
//   busy                                   pending buffer non-empty
// AW/DW must match the package widths since buffered entries use wb_entry_t.
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = WB_DW,
    parameter int AW    = WB_AW
) (
    input  logic          clock,
    input  logic          ctrl_reset,
    input  logic          pipe_valid,
    input  logic [AW-1:0] pipe_rd,
    input  logic [DW-1:0] pipe_data,
    input  logic          md_valid,
    output logic          md_ready,
    input  logic [AW-1:0] md_rd,
    input  logic [DW-1:0] md_data,
    output logic          ctrl_writeEnable,
    output logic [AW-1:0] ctrl_writeReg,
    output logic [DW-1:0] data_writeReg,
    input  logic [AW-1:0] fwd_regA,
    input  logic [AW-1:0] fwd_regB,
    output logic          fwd_hitA,
    output logic          fwd_hitB,
    output logic [DW-1:0] fwd_dataA,
    output logic [DW-1:0] fwd_dataB,
    output logic          fwd_stallA,
    output logic          fwd_stallB,
    output logic          busy
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          we_q, we_d;
    logic [AW-1:0] wreg_q, wreg_d;
    logic [DW-1:0] wdata_q, wdata_d;

    wb_entry_t        fifo_head, fifo_in;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty;
    logic             fifo_push, fifo_pop;
    logic [AW-1:0]    qa_rd, qb_rd;
    logic [DEPTH-1:0] match_a, match_b, match_pipe;
    logic             md_xfer;

    assign md_ready = !ctrl_reset && (fifo_count < CW'(DEPTH));
    assign md_xfer  = md_valid && md_ready;
    assign fifo_in  = '{rd: md_rd, data: md_data};

    // Pipeline first, then the buffer head, then a direct multdiv bypass.
    // A multdiv transfer bypasses only when the buffer is empty so buffered
    // results always drain in arrival order.
    always_comb begin
        we_d      = 1'b0;
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (pipe_valid) begin
            we_d      = (pipe_rd != WB_R0);
            wreg_d    = pipe_rd;
            wdata_d   = pipe_data;
            fifo_push = md_xfer && (md_rd != WB_R0);
        end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            we_d      = (fifo_head.rd != WB_R0);
            wreg_d    = fifo_head.rd;
            wdata_d   = fifo_head.data;
            fifo_push = md_xfer && (md_rd != WB_R0);
        end else if (md_xfer) begin
            we_d      = (md_rd != WB_R0);
            wreg_d    = md_rd;
            wdata_d   = md_data;
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .push_i       (fifo_push),
        .push_entry_i (fifo_in),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .qa_rd_i      (qa_rd),
        .qb_rd_i      (qb_rd),
        .qc_rd_i      (pipe_rd),
        .match_a_o    (match_a),
        .match_b_o    (match_b),
        .match_c_o    (match_pipe)
    );

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;
    assign busy             = !ctrl_reset && !fifo_empty;

    logic unused_full;
    assign unused_full = fifo_full;

`ifdef REGFILE_WB_FWD_EN
    assign qa_rd      = fwd_regA;
    assign qb_rd      = fwd_regB;
    assign fwd_hitA   = !ctrl_reset && we_q && (wreg_q == fwd_regA) && (fwd_regA != WB_R0);
    assign fwd_hitB   = !ctrl_reset && we_q && (wreg_q == fwd_regB) && (fwd_regB != WB_R0);
    assign fwd_dataA  = fwd_hitA ? wdata_q : '0;
    assign fwd_dataB  = fwd_hitB ? wdata_q : '0;
    assign fwd_stallA = !ctrl_reset && (|match_a);
    assign fwd_stallB = !ctrl_reset && (|match_b);
`else
    // R0 queries never match, so the buffer comparators fold away.
    assign qa_rd      = WB_R0;
    assign qb_rd      = WB_R0;
    assign fwd_hitA   = 1'b0;
    assign fwd_hitB   = 1'b0;
    assign fwd_dataA  = '0;
    assign fwd_dataB  = '0;
    // Without address compares, any pending multdiv result stalls every read.
    assign fwd_stallA = busy;
    assign fwd_stallB = busy;
    logic unused_fwd;
    assign unused_fwd = ^{fwd_regA, fwd_regB, match_a, match_b};
`endif

    // Decode must never issue a pipeline write to a register still waiting in the buffer.
    a_no_waw: assert property (@(posedge clock) disable iff (ctrl_reset) !(pipe_valid && (|match_pipe)));

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - self-checking bench for regfile_writeback
module tb_regfile_writeback;

    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clock = 1'b0;
    logic          ctrl_reset;
    logic          pipe_valid;
    logic [AW-1:0] pipe_rd;
    logic [DW-1:0] pipe_data;
    logic          md_valid;
    logic          md_ready;
    logic [AW-1:0] md_rd;
    logic [DW-1:0] md_data;
    logic          ctrl_writeEnable;
    logic [AW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
    logic [AW-1:0] fwd_regA, fwd_regB;
    logic          fwd_hitA, fwd_hitB;
    logic [DW-1:0] fwd_dataA, fwd_dataB;
    logic          fwd_stallA, fwd_stallB;
    logic          busy;

    always #5 clock = ~clock;

    regfile_writeback #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .pipe_valid       (pipe_valid),
        .pipe_rd          (pipe_rd),
        .pipe_data        (pipe_data),
        .md_valid         (md_valid),
        .md_ready         (md_ready),
        .md_rd            (md_rd),
        .md_data          (md_data),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .fwd_regA         (fwd_regA),
        .fwd_regB         (fwd_regB),
        .fwd_hitA         (fwd_hitA),
        .fwd_hitB         (fwd_hitB),
        .fwd_dataA        (fwd_dataA),
        .fwd_dataB        (fwd_dataB),
        .fwd_stallA       (fwd_stallA),
        .fwd_stallB       (fwd_stallB),
        .busy             (busy)
    );

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          m_pend[$];
    logic          m_we   = 1'b0;
    logic [AW-1:0] m_rd   = '0;
    logic [DW-1:0] m_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: pending results in a queue, one write-stage slot.
    task automatic model_tick();
        ent_t e;
        bit   acc;
        bit   win;
        if (ctrl_reset) begin
            m_pend.delete();
            m_we = 1'b0; m_rd = '0; m_data = '0;
        end else begin
            acc = md_valid && (m_pend.size() < DEPTH);
            win = 1'b1;
            e.rd = '0; e.data = '0;
            if (pipe_valid) begin
                e.rd = pipe_rd; e.data = pipe_data;
            end else if (m_pend.size() > 0) begin
                e = m_pend.pop_front();
            end else if (acc) begin
                e.rd = md_rd; e.data = md_data;
                acc = 1'b0;
            end else begin
                win = 1'b0;
            end
            if (acc && md_rd != 0) begin
                ent_t n;
                n.rd = md_rd; n.data = md_data;
                m_pend.push_back(n);
            end
            if (win) begin
                m_we = (e.rd != 0); m_rd = e.rd; m_data = e.data;
            end else begin
                m_we = 1'b0;
            end
        end
    endtask

    function automatic bit in_pend(logic [AW-1:0] r);
        foreach (m_pend[i]) if (m_pend[i].rd == r && r != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_ready();
        return !ctrl_reset && (m_pend.size() < DEPTH);
    endfunction

    function automatic bit exp_busy();
        return !ctrl_reset && (m_pend.size() > 0);
    endfunction

    function automatic bit exp_hit(logic [AW-1:0] r);
`ifdef REGFILE_WB_FWD_EN
        return !ctrl_reset && m_we && (m_rd == r) && (r != 0);
`else
        return (r == '1) && (r == '0);
`endif
    endfunction

    function automatic bit exp_stall(logic [AW-1:0] r);
`ifdef REGFILE_WB_FWD_EN
        return !ctrl_reset && in_pend(r);
`else
        return exp_busy() && (r == r);
`endif
    endfunction

    task automatic idle();
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        md_valid   = 1'b0; md_rd   = '0; md_data   = '0;
    endtask

    task automatic tick();
        model_tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b1;
        idle();
        pipe_valid = 1'b1; pipe_rd = 5'd2; md_valid = 1'b1; md_rd = 5'd4;
        fwd_regA = 5'd4; fwd_regB = 5'd2;
        #1;
        n_checks++; if (md_ready !== 1'b0) begin n_errors++; $display("FAIL reset_md_ready: got %0b want 0", md_ready); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if ({fwd_hitA, fwd_hitB, fwd_stallA, fwd_stallB} !== 4'b0) begin n_errors++; $display("FAIL reset_fwd: got %0b want 0", {fwd_hitA, fwd_hitB, fwd_stallA, fwd_stallB}); end
        tick();
        n_checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== '0) begin n_errors++; $display("FAIL reset_wstage: got %0b/%0h/%0h want 0/0/0", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
        ctrl_reset = 1'b0;
        idle();
        #1;
        n_checks++; if (md_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_md_ready: got %0b want 1", md_ready); end
        tick();
    endtask

    task automatic test_pipe_write();
        idle();
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hDEADBEEF;
        tick();
        idle();
        n_checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin n_errors++; $display("FAIL pipe_write: got %0b/%0d/%0h want 1/3/deadbeef", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
        tick();
        n_checks++; if (ctrl_writeEnable !== 1'b0) begin n_errors++; $display("FAIL pipe_idle_we: got %0b want 0", ctrl_writeEnable); end
        n_checks++; if ({ctrl_writeReg, data_writeReg} !== {5'd3, 32'hDEADBEEF}) begin n_errors++; $display("FAIL pipe_idle_hold: got %0d/%0h want 3/deadbeef", ctrl_writeReg, data_writeReg); end
    endtask

    task automatic test_md_bypass();
        idle();
        md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h12345678;
        #1;
        n_checks++; if (md_ready !== 1'b1) begin n_errors++; $display("FAIL bypass_ready: got %0b want 1", md_ready); end
        tick();
        idle();
        n_checks++; if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd7, 32'h12345678}) begin n_errors++; $display("FAIL bypass_write: got %0b/%0d/%0h want 1/7/12345678", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL bypass_busy: got %0b want 0", busy); end
        tick();
    endtask

    task automatic test_md_buffered();
        logic [AW-1:0] exp_seq [6];
        exp_seq[0] = 5'd1; exp_seq[1] = 5'd2; exp_seq[2] = 5'd3;
        exp_seq[3] = 5'd4; exp_seq[4] = 5'd9; exp_seq[5] = 5'd10;
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c < 4) begin
                pipe_valid = 1'b1; pipe_rd = AW'(c + 1); pipe_data = 32'h100 + c;
            end
            if (c < 2) begin
                md_valid = 1'b1; md_rd = AW'(9 + c); md_data = 32'h900 + c;
            end
            fwd_regA = 5'd9; fwd_regB = 5'd10;
            #1;
            if (c == 2) begin
                n_checks++; if (md_ready !== 1'b0) begin n_errors++; $display("FAIL buf_full_ready: got %0b want 0", md_ready); end
                n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL buf_busy: got %0b want 1", busy); end
                n_checks++; if (fwd_stallA !== 1'b1) begin n_errors++; $display("FAIL buf_stallA_r9: got %0b want 1", fwd_stallA); end
            end
            tick();
            n_checks++; if ({ctrl_writeEnable, ctrl_writeReg} !== {1'b1, exp_seq[c]}) begin n_errors++; $display("FAIL buf_order[%0d]: got %0b/%0d want 1/%0d", c, ctrl_writeEnable, ctrl_writeReg, exp_seq[c]); end
        end
        n_checks++; if (data_writeReg !== 32'h901) begin n_errors++; $display("FAIL buf_r10_data: got %0h want 901", data_writeReg); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL buf_drained_busy: got %0b want 0", busy); end
        idle();
        tick();
    endtask

    task automatic test_r0();
        idle();
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h55;
        tick();
        n_checks++; if (ctrl_writeEnable !== 1'b0) begin n_errors++; $display("FAIL r0_pipe_we: got %0b want 0", ctrl_writeEnable); end
        idle();
        md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h66;
        tick();
        n_checks++; if (ctrl_writeEnable !== 1'b0) begin n_errors++; $display("FAIL r0_md_we: got %0b want 0", ctrl_writeEnable); end
        idle();
        pipe_valid = 1'b1; pipe_rd = 5'd6; pipe_data = 32'h77;
        md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h88;
        tick();
        idle();
        fwd_regA = 5'd0; fwd_regB = 5'd6;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL r0_not_enqueued: got busy=%0b want 0", busy); end
        n_checks++; if (fwd_hitA !== 1'b0) begin n_errors++; $display("FAIL r0_no_hit: got %0b want 0", fwd_hitA); end
        tick();
    endtask

    task automatic test_forward();
        idle();
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hCAFE;
        tick();
        idle();
        fwd_regA = 5'd6; fwd_regB = 5'd5;
        #1;
`ifdef REGFILE_WB_FWD_EN
        n_checks++; if ({fwd_hitB, fwd_dataB} !== {1'b1, 32'hCAFE}) begin n_errors++; $display("FAIL fwd_hitB: got %0b/%0h want 1/cafe", fwd_hitB, fwd_dataB); end
`else
        n_checks++; if ({fwd_hitB, fwd_dataB} !== {1'b0, 32'h0}) begin n_errors++; $display("FAIL fwd_hitB: got %0b/%0h want 0/0", fwd_hitB, fwd_dataB); end
`endif
        n_checks++; if ({fwd_hitA, fwd_dataA} !== {1'b0, 32'h0}) begin n_errors++; $display("FAIL fwd_missA: got %0b/%0h want 0/0", fwd_hitA, fwd_dataA); end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            idle();
            pipe_valid = 1'b1; pipe_rd = AW'(11 + c); pipe_data = 32'hA0 + c;
            md_valid = 1'b1; md_rd = AW'(20 + c); md_data = 32'hB0 + c;
            tick();
        end
        idle();
        #1;
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL mid_prefill_busy: got %0b want 1", busy); end
        ctrl_reset = 1'b1;
        fwd_regA = 5'd20;
        #1;
        n_checks++; if ({md_ready, busy} !== 2'b00) begin n_errors++; $display("FAIL mid_in_reset: got ready/busy %0b/%0b want 0/0", md_ready, busy); end
        tick();
        ctrl_reset = 1'b0;
        #1;
        n_checks++; if ({md_ready, busy, fwd_stallA} !== 3'b100) begin n_errors++; $display("FAIL mid_after_reset: got ready/busy/stall %0b/%0b/%0b want 1/0/0", md_ready, busy, fwd_stallA); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (ctrl_writeEnable !== 1'b0) begin n_errors++; $display("FAIL mid_discarded[%0d]: got we=%0b reg=%0d want 0", c, ctrl_writeEnable, ctrl_writeReg); end
        end
    endtask

    task automatic test_random(input int n);
        bit stuck;
        stuck = 1'b0;
        for (int c = 0; c < n; c++) begin
            ctrl_reset = ($urandom_range(0, 39) == 0);
            pipe_valid = $urandom_range(0, 1);
            pipe_rd    = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
            pipe_data  = $urandom;
            if (pipe_valid && in_pend(pipe_rd)) pipe_valid = 1'b0;
            if (!stuck) begin
                md_valid = ($urandom_range(0, 2) != 0);
                md_rd    = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
                md_data  = $urandom;
            end
            case ($urandom_range(0, 2))
                0:       fwd_regA = m_rd;
                1:       fwd_regA = (m_pend.size() > 0) ? m_pend[0].rd : AW'($urandom_range(0, 31));
                default: fwd_regA = AW'($urandom_range(0, 31));
            endcase
            fwd_regB = ($urandom_range(0, 1) == 0) ? ((m_pend.size() > 0) ? m_pend[m_pend.size() - 1].rd : m_rd)
                                                   : AW'($urandom_range(0, 31));
            #1;
            n_checks++; if (md_ready !== exp_ready()) begin n_errors++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", c, md_ready, exp_ready()); end
            n_checks++; if (busy !== exp_busy()) begin n_errors++; $display("FAIL rnd_busy[%0d]: got %0b want %0b", c, busy, exp_busy()); end
            n_checks++; if ({fwd_hitA, fwd_dataA} !== {exp_hit(fwd_regA), exp_hit(fwd_regA) ? m_data : 32'h0}) begin n_errors++; $display("FAIL rnd_fwdA[%0d]: got %0b/%0h want %0b", c, fwd_hitA, fwd_dataA, exp_hit(fwd_regA)); end
            n_checks++; if ({fwd_hitB, fwd_dataB} !== {exp_hit(fwd_regB), exp_hit(fwd_regB) ? m_data : 32'h0}) begin n_errors++; $display("FAIL rnd_fwdB[%0d]: got %0b/%0h want %0b", c, fwd_hitB, fwd_dataB, exp_hit(fwd_regB)); end
            n_checks++; if ({fwd_stallA, fwd_stallB} !== {exp_stall(fwd_regA), exp_stall(fwd_regB)}) begin n_errors++; $display("FAIL rnd_stall[%0d]: got %0b%0b want %0b%0b", c, fwd_stallA, fwd_stallB, exp_stall(fwd_regA), exp_stall(fwd_regB)); end
            stuck = md_valid && !exp_ready();
            tick();
            n_checks++; if (ctrl_writeEnable !== m_we) begin n_errors++; $display("FAIL rnd_we[%0d]: got %0b want %0b", c, ctrl_writeEnable, m_we); end
            if (m_we) begin
                n_checks++; if ({ctrl_writeReg, data_writeReg} !== {m_rd, m_data}) begin n_errors++; $display("FAIL rnd_write[%0d]: got %0d/%0h want %0d/%0h", c, ctrl_writeReg, data_writeReg, m_rd, m_data); end
            end
        end
        ctrl_reset = 1'b0;
        idle();
        tick();
    endtask

    initial begin
        ctrl_reset = 1'b1;
        fwd_regA = '0;
        fwd_regB = '0;
        idle();
        #1;
        test_reset();
        test_pipe_write();
        test_md_bypass();
        test_md_buffered();
        test_r0();
        test_forward();
        test_reset_mid();
        test_random(400);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
